// File: rtl/slave_read_master_if.sv
// Signal bundle between the read initiator (master) and the slave-side
// environment that supplies start requests and returns read data.
interface slave_read_master_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [7:0]        msg_len;
    logic              ram_rd_rq;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data_i;
    logic              new_msg;
    logic              busy;
    logic              done;
    logic [15:0]       header;
    logic              header_valid;
    logic              stale_err;
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic [7:0]        byte_idx;

    modport master (
        input  start, msg_len, data_i,
        output ram_rd_rq, rd_addr, new_msg, busy, done,
               header, header_valid, stale_err,
               byte_data, byte_valid, byte_idx
    );

    modport slave (
        output start, msg_len, data_i,
        input  ram_rd_rq, rd_addr, new_msg, busy, done,
               header, header_valid, stale_err,
               byte_data, byte_valid, byte_idx
    );
endinterface

// File: rtl/slave_read_master.sv
// Read initiator: notifies the slave, bursts header+payload reads, and
// re-associates returning data with its address via a latency-matched tag pipe.
module slave_read_master #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input logic                 clk,
    input logic                 rst_l,
    slave_read_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        NOTIFY,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [8:0]        last_addr;
    logic              rq;

    logic [RD_LAT-1:0] pv_q;
    logic [8:0]        pt_q [RD_LAT];
    logic              ex_v;
    logic [8:0]        ex_tag;

    logic [7:0]        hi_q;
    logic [15:0]       header_q;
    logic [15:0]       prev_hdr_q;
    logic [15:0]       new_hdr;
    logic              first_q;
    logic              hv_q;
    logic              stale_q;
    logic              bv_q;
    logic [DATA_W-1:0] bdata_q;
    logic [7:0]        bidx_q;

    assign last_addr = {1'b0, len_q} + 9'd1;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rq      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.msg_len;
                    cnt_d   = '0;
                    state_d = NOTIFY;
                end
            end
            NOTIFY: begin
                cnt_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                rq    = 1'b1;
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == last_addr) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pv_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from state so reset removes them without waiting for a clock.
    assign bus.ram_rd_rq = rq;
    assign bus.rd_addr   = rq ? ADDR_W'(cnt_q) : '0;
    assign bus.new_msg   = (state_q == NOTIFY);
    assign bus.busy      = (state_q == NOTIFY) || (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);

    // Tag pipe mirrors the slave's register stages so each data_i meets its address.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) pt_q[i] <= '0;
        end else begin
            pv_q[0] <= rq;
            pt_q[0] <= rq ? cnt_q : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
        end
    end

    assign ex_v    = pv_q[RD_LAT-1];
    assign ex_tag  = pt_q[RD_LAT-1];
    assign new_hdr = {hi_q, bus.data_i[7:0]};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hi_q       <= '0;
            header_q   <= '0;
            prev_hdr_q <= '0;
            first_q    <= 1'b1;
            hv_q       <= 1'b0;
            stale_q    <= 1'b0;
            bv_q       <= 1'b0;
            bdata_q    <= '0;
            bidx_q     <= '0;
        end else begin
            hv_q    <= 1'b0;
            stale_q <= 1'b0;
            bv_q    <= 1'b0;
            if (ex_v) begin
                if (ex_tag == 9'd0) begin
                    hi_q <= bus.data_i[7:0];
                end else if (ex_tag == 9'd1) begin
                    header_q   <= new_hdr;
                    hv_q       <= 1'b1;
                    stale_q    <= !first_q && (new_hdr == prev_hdr_q);
                    prev_hdr_q <= new_hdr;
                    first_q    <= 1'b0;
                end else begin
                    bdata_q <= bus.data_i;
                    bidx_q  <= 8'(ex_tag - 9'd2);
                    bv_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.header       = header_q;
    assign bus.header_valid = hv_q;
    assign bus.stale_err    = stale_q;
    assign bus.byte_data    = bdata_q;
    assign bus.byte_valid   = bv_q;
    assign bus.byte_idx     = bidx_q;

endmodule

// File: tb/tb_slave_read_master.sv
// Bench for slave_read_master: a latency-accurate slave memory model feeds
// data_i, and header/byte pulses are matched against a queue of expectations.
module tb_slave_read_master;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_l;

    always #5 clk = ~clk;

    slave_read_master_if #(.DATA_W(8), .ADDR_W(16)) bus ();

    slave_read_master #(
        .RD_LAT(RD_LAT),
        .DATA_W(8),
        .ADDR_W(16)
    ) dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus)
    );

    // Slave model: RD_LAT register stages on the address, then memory lookup.
    logic [7:0]  mem [512];
    logic [15:0] sa  [RD_LAT];

    always @(posedge clk) begin
        sa[0] <= bus.rd_addr;
        for (int i = 1; i < RD_LAT; i++) sa[i] <= sa[i-1];
    end

    assign bus.data_i = mem[sa[RD_LAT-1][8:0]];

    logic [16:0] hdr_q  [$];
    logic [15:0] byte_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // One cycle step: sample at negedge and retire any header/byte pulse against the queues.
    task automatic tick();
        logic [16:0] eh;
        logic [15:0] eb;
        @(negedge clk);
        if (bus.done === 1'b1) done_cnt++;
        if (bus.header_valid === 1'b1) begin
            n_checks++;
            if (hdr_q.size() == 0) begin
                $display("FAIL hdr_unexpected: got header=%h stale=%b, none expected", bus.header, bus.stale_err);
            end else begin
                eh = hdr_q.pop_front();
                if ({bus.stale_err, bus.header} !== eh)
                    $display("FAIL hdr: got stale=%b header=%h, exp stale=%b header=%h",
                             bus.stale_err, bus.header, eh[16], eh[15:0]);
                else n_pass++;
            end
        end else if (bus.stale_err !== 1'b0) begin
            n_checks++;
            $display("FAIL stale_alone: got stale_err=%b without header_valid, exp 0", bus.stale_err);
        end
        if (bus.byte_valid === 1'b1) begin
            n_checks++;
            if (byte_q.size() == 0) begin
                $display("FAIL byte_unexpected: got idx=%0d data=%h, none expected", bus.byte_idx, bus.byte_data);
            end else begin
                eb = byte_q.pop_front();
                if ({bus.byte_idx, bus.byte_data} !== eb)
                    $display("FAIL byte: got idx=%0d data=%h, exp idx=%0d data=%h",
                             bus.byte_idx, bus.byte_data, eb[15:8], eb[7:0]);
                else n_pass++;
            end
        end
    endtask

    // Runs one message from start to a couple of cycles past done, checking cycle-exact timing.
    task automatic run_msg(input logic [15:0] hdr, input logic [7:0] len, input logic [7:0] base,
                           input logic stale, input bit poke);
        int          done_at;
        int          d0;
        logic        exp_rq;
        logic [15:0] exp_addr;
        logic        exp_busy;
        mem[0] = hdr[15:8];
        mem[1] = hdr[7:0];
        for (int i = 0; i < int'(len); i++) begin
            mem[i+2] = base + 8'(i);
            byte_q.push_back({8'(i), base + 8'(i)});
        end
        hdr_q.push_back({stale, hdr});
        done_at     = int'(len) + 5 + RD_LAT;
        d0          = done_cnt;
        bus.msg_len = len;
        bus.start   = 1'b1;
        for (int k = 1; k <= done_at + 2; k++) begin
            tick();
            exp_rq   = (k >= 2) && (k <= int'(len) + 3);
            exp_addr = exp_rq ? 16'(k - 2) : 16'd0;
            exp_busy = (k >= 1) && (k < done_at);
            n_checks++;
            if (bus.new_msg !== (k == 1))
                $display("FAIL new_msg@%0d: got %b, exp %b", k, bus.new_msg, (k == 1));
            else n_pass++;
            n_checks++;
            if ({bus.ram_rd_rq, bus.rd_addr} !== {exp_rq, exp_addr})
                $display("FAIL issue@%0d: got rq=%b addr=%0d, exp rq=%b addr=%0d",
                         k, bus.ram_rd_rq, bus.rd_addr, exp_rq, exp_addr);
            else n_pass++;
            n_checks++;
            if (bus.busy !== exp_busy)
                $display("FAIL busy@%0d: got %b, exp %b", k, bus.busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (bus.done !== (k == done_at))
                $display("FAIL done@%0d: got %b, exp %b", k, bus.done, (k == done_at));
            else n_pass++;
            if (k == 1) bus.start = 1'b0;
            if (poke && k == 4) bus.start = 1'b1;
            if (poke && k == 5) bus.start = 1'b0;
            if (poke && k == done_at) bus.start = 1'b1;
            if (poke && k == done_at + 1) bus.start = 1'b0;
        end
        n_checks++;
        if (hdr_q.size() != 0 || byte_q.size() != 0)
            $display("FAIL drained: got %0d hdr / %0d bytes outstanding, exp 0/0", hdr_q.size(), byte_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1)
            $display("FAIL done_count: got %0d, exp 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (bus.header !== hdr)
            $display("FAIL header_hold: got %h, exp %h", bus.header, hdr);
        else n_pass++;
        if (len != 0) begin
            n_checks++;
            if ({bus.byte_idx, bus.byte_data} !== {len - 8'd1, base + len - 8'd1})
                $display("FAIL byte_hold: got idx=%0d data=%h, exp idx=%0d data=%h",
                         bus.byte_idx, bus.byte_data, len - 8'd1, base + len - 8'd1);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [54:0] outs;
        for (int k = 0; k < 3; k++) begin
            tick();
            outs = {bus.ram_rd_rq, bus.rd_addr, bus.new_msg, bus.busy, bus.done, bus.header,
                    bus.header_valid, bus.stale_err, bus.byte_data, bus.byte_valid, bus.byte_idx};
            n_checks++;
            if (outs !== '0) $display("FAIL reset_outs: got %h, exp 0", outs);
            else n_pass++;
        end
        rst_l = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            outs = {bus.ram_rd_rq, bus.rd_addr, bus.new_msg, bus.busy, bus.done, bus.header,
                    bus.header_valid, bus.stale_err, bus.byte_data, bus.byte_valid, bus.byte_idx};
            n_checks++;
            if (outs !== '0) $display("FAIL idle_outs@%0d: got %h, exp 0", k, outs);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        run_msg(16'h1234, 8'd3, 8'hA0, 1'b0, 1'b0);
    endtask

    task automatic test_stale();
        run_msg(16'h0005, 8'd1, 8'h40, 1'b0, 1'b0);
        run_msg(16'h0005, 8'd1, 8'h50, 1'b1, 1'b0);
        run_msg(16'h0006, 8'd1, 8'h60, 1'b0, 1'b0);
    endtask

    task automatic test_len0();
        run_msg(16'hBEEF, 8'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start();
        run_msg(16'h4321, 8'd2, 8'h30, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({bus.busy, bus.new_msg} !== 2'b00)
                $display("FAIL busy_reentry@%0d: got busy=%b new_msg=%b, exp 0 0", k, bus.busy, bus.new_msg);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int          k;
        int          d0;
        bit          found;
        logic [54:0] outs;
        mem[0] = 8'h77;
        mem[1] = 8'h77;
        for (int i = 2; i < 12; i++) mem[i] = 8'(i);
        hdr_q.push_back({1'b0, 16'h7777});
        bus.msg_len = 8'd10;
        bus.start   = 1'b1;
        found       = 1'b0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) bus.start = 1'b0;
            if (bus.ram_rd_rq === 1'b1 && bus.rd_addr === 16'd4) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || k != 6) $display("FAIL addr4_cycle: got found=%b cycle=%0d, exp found=1 cycle=6", found, k);
        else n_pass++;
        d0    = done_cnt;
        rst_l = 1'b0;
        #1;
        n_checks++;
        if ({bus.ram_rd_rq, bus.busy, bus.new_msg} !== 3'b000)
            $display("FAIL async_reset: got rq=%b busy=%b new_msg=%b, exp 0 0 0", bus.ram_rd_rq, bus.busy, bus.new_msg);
        else n_pass++;
        tick();
        tick();
        outs = {bus.ram_rd_rq, bus.rd_addr, bus.new_msg, bus.busy, bus.done, bus.header,
                bus.header_valid, bus.stale_err, bus.byte_data, bus.byte_valid, bus.byte_idx};
        n_checks++;
        if (outs !== '0) $display("FAIL mid_reset_outs: got %h, exp 0", outs);
        else n_pass++;
        rst_l = 1'b1;
        for (int j = 0; j < 20; j++) tick();
        n_checks++;
        if (done_cnt != d0 || hdr_q.size() != 0 || byte_q.size() != 0)
            $display("FAIL post_reset_quiet: got done=%0d hdr=%0d bytes=%0d, exp 0 0 0",
                     done_cnt - d0, hdr_q.size(), byte_q.size());
        else n_pass++;
        run_msg(16'h2222, 8'd2, 8'h10, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        run_msg(16'h0102, 8'd255, 8'h5A, 1'b0, 1'b0);
    endtask

    initial begin
        rst_l       = 1'b0;
        bus.start   = 1'b0;
        bus.msg_len = 8'd0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_stale();
        test_len0();
        test_busy_start();
        test_reset_mid();
        test_max_len();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
